// File: rtl/gate_pkg.sv
// Shared constants for the two-input gate tester: state encoding, gate bit positions and
// pattern width.
package gate_pkg;

  localparam int unsigned PATTERN_W = 2;
  localparam int unsigned GATE_NUM  = 6;

  localparam logic [PATTERN_W-1:0] PATTERN_LAST = 2'b11;

  localparam int unsigned GATE_AND  = 0;
  localparam int unsigned GATE_NAND = 1;
  localparam int unsigned GATE_OR   = 2;
  localparam int unsigned GATE_NOR  = 3;
  localparam int unsigned GATE_XOR  = 4;
  localparam int unsigned GATE_XNOR = 5;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = IDLE,
    StSettle = SETTLE,
    StSample = SAMPLE,
    StDone   = DONE
  } state_t;

endpackage

// File: rtl/gate_ref_model.sv
// Golden combinational truth table for the two-input gate block (a = pattern[0], b = pattern[1]).
module gate_ref_model
  import gate_pkg::*;
(
  input  logic [PATTERN_W-1:0] pattern,
  output logic [GATE_NUM-1:0]  expected
);

  logic a;
  logic b;

  assign a = pattern[0];
  assign b = pattern[1];

  always_comb begin
    expected            = '0;
    expected[GATE_AND]  = a & b;
    expected[GATE_NAND] = ~(a & b);
    expected[GATE_OR]   = a | b;
    expected[GATE_NOR]  = ~(a | b);
    expected[GATE_XOR]  = a ^ b;
    expected[GATE_XNOR] = ~(a ^ b);
  end

endmodule

// File: rtl/gate_tester.sv
// Stimulus/check sequencer for the two-input gate block; optional first-failure log is
// enabled by defining GATE_TESTER_FAIL_LOG_EN.
module gate_tester
  import gate_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 Start_Sig,
  output logic [PATTERN_W-1:0] Test_Gate_In,
  input  logic [GATE_NUM-1:0]  Test_Gate_Out,
  output logic                 Busy_Sig,
  output logic                 Done_Sig,
  output logic [GATE_NUM-1:0]  Pass_Vec
`ifdef GATE_TESTER_FAIL_LOG_EN
  ,
  output logic                 Fail_Valid,
  output logic [PATTERN_W-1:0] Fail_Pattern,
  output logic [GATE_NUM-1:0]  Fail_Gates
`endif
);

  localparam logic [7:0] SettleLoad = 8'(SETTLE_CYCLES - 1);

  state_t                state_q;
  logic [PATTERN_W-1:0]  pattern_q;
  logic [7:0]            cnt_q;
  logic                  busy_q;
  logic                  done_q;
  logic [GATE_NUM-1:0]   pass_q;
  logic [GATE_NUM-1:0]   expected;
  logic [GATE_NUM-1:0]   mismatch;

  gate_ref_model u_ref (
    .pattern  (pattern_q),
    .expected (expected)
  );

  assign mismatch = Test_Gate_Out ^ expected;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= StIdle;
      pattern_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (Start_Sig) begin
            pattern_q <= '0;
            pass_q    <= '1;
            cnt_q     <= SettleLoad;
            busy_q    <= 1'b1;
            state_q   <= StSettle;
          end
        end
        StSettle: begin
          if (cnt_q == 8'd0) begin
            state_q <= StSample;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StSample: begin
          pass_q <= pass_q & ~mismatch;
          if (pattern_q == PATTERN_LAST) begin
            // Pattern drops back to 00 entering DONE so 11 is held no longer than the others.
            pattern_q <= '0;
            done_q    <= 1'b1;
            state_q   <= StDone;
          end else begin
            pattern_q <= pattern_q + 1'b1;
            cnt_q     <= SettleLoad;
            state_q   <= StSettle;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Test_Gate_In = pattern_q;
  assign Busy_Sig     = busy_q;
  assign Done_Sig     = done_q;
  assign Pass_Vec     = pass_q;

`ifdef GATE_TESTER_FAIL_LOG_EN
  logic                 fail_valid_q;
  logic [PATTERN_W-1:0] fail_pattern_q;
  logic [GATE_NUM-1:0]  fail_gates_q;

  // Only the first mismatching SAMPLE of a run is kept.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      fail_valid_q   <= 1'b0;
      fail_pattern_q <= '0;
      fail_gates_q   <= '0;
    end else if (state_q == StIdle && Start_Sig) begin
      fail_valid_q   <= 1'b0;
      fail_pattern_q <= '0;
      fail_gates_q   <= '0;
    end else if (state_q == StSample && !fail_valid_q && (|mismatch)) begin
      fail_valid_q   <= 1'b1;
      fail_pattern_q <= pattern_q;
      fail_gates_q   <= mismatch;
    end
  end

  assign Fail_Valid   = fail_valid_q;
  assign Fail_Pattern = fail_pattern_q;
  assign Fail_Gates   = fail_gates_q;
`endif

endmodule

// File: tb/tb_gate_tester.sv
// Self-checking bench for gate_tester: cycle-indexed behavioural model plus directed and
// randomized fault-injection runs.
module tb_gate_tester;

  localparam int unsigned S   = 4;
  localparam int unsigned RUN = 4 * (S + 1) + 1;

  logic       CLK;
  logic       RSTn;
  logic       Start_Sig;
  logic [1:0] Test_Gate_In;
  logic [5:0] Test_Gate_Out;
  logic       Busy_Sig;
  logic       Done_Sig;
  logic [5:0] Pass_Vec;
`ifdef GATE_TESTER_FAIL_LOG_EN
  logic       Fail_Valid;
  logic [1:0] Fail_Pattern;
  logic [5:0] Fail_Gates;
`endif

  logic [5:0] golden_out;
  logic [5:0] stuck0;
  logic [5:0] inv_arr [4];

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  gate_tester #(.SETTLE_CYCLES(S)) dut (
    .CLK           (CLK),
    .RSTn          (RSTn),
    .Start_Sig     (Start_Sig),
    .Test_Gate_In  (Test_Gate_In),
    .Test_Gate_Out (Test_Gate_Out),
    .Busy_Sig      (Busy_Sig),
    .Done_Sig      (Done_Sig),
    .Pass_Vec      (Pass_Vec)
`ifdef GATE_TESTER_FAIL_LOG_EN
    ,
    .Fail_Valid    (Fail_Valid),
    .Fail_Pattern  (Fail_Pattern),
    .Fail_Gates    (Fail_Gates)
`endif
  );

  // Faultable gate block: golden outputs with stuck-at-0 and per-pattern inversion masks.
  gate_ref_model u_gate (
    .pattern  (Test_Gate_In),
    .expected (golden_out)
  );
  assign Test_Gate_Out = (golden_out & ~stuck0) ^ inv_arr[Test_Gate_In];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Truth table as columns: bit p of each entry is the gate output for pattern p.
  function automatic logic [5:0] truth(input logic [1:0] p);
    logic [3:0] tt [6];
    logic [5:0] r;
    tt[0] = 4'b1000; tt[1] = 4'b0111; tt[2] = 4'b1110;
    tt[3] = 4'b0001; tt[4] = 4'b0110; tt[5] = 4'b1001;
    for (int g = 0; g < 6; g++) r[g] = tt[g][p];
    return r;
  endfunction

  function automatic logic [5:0] mis(input logic [1:0] p);
    return (truth(p) & stuck0) ^ inv_arr[p];
  endfunction

  // Model: k = cycle number within a run (0 when idle, 1..RUN while busy).
  int unsigned k;
  logic [5:0]  m_pass;
`ifdef GATE_TESTER_FAIL_LOG_EN
  logic        m_fv;
  logic [1:0]  m_fp;
  logic [5:0]  m_fg;
`endif

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      k      <= 0;
      m_pass <= '0;
`ifdef GATE_TESTER_FAIL_LOG_EN
      m_fv <= 1'b0; m_fp <= '0; m_fg <= '0;
`endif
    end else if (k == 0) begin
      if (Start_Sig) begin
        k      <= 1;
        m_pass <= 6'h3f;
`ifdef GATE_TESTER_FAIL_LOG_EN
        m_fv <= 1'b0; m_fp <= '0; m_fg <= '0;
`endif
      end
    end else begin
      if (k % (S + 1) == 0) begin
        m_pass <= m_pass & ~mis(2'(k / (S + 1) - 1));
`ifdef GATE_TESTER_FAIL_LOG_EN
        if (!m_fv && mis(2'(k / (S + 1) - 1)) != 6'd0) begin
          m_fv <= 1'b1;
          m_fp <= 2'(k / (S + 1) - 1);
          m_fg <= mis(2'(k / (S + 1) - 1));
        end
`endif
      end
      k <= (k == RUN) ? 0 : k + 1;
    end
  end

  function automatic logic [1:0] exp_pat(input int unsigned kk);
    return (kk >= 1 && kk < RUN) ? 2'((kk - 1) / (S + 1)) : 2'b00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("busy",     32'(Busy_Sig),     32'(k != 0));
      check("done",     32'(Done_Sig),     32'(k == RUN));
      check("gate_in",  32'(Test_Gate_In), 32'(exp_pat(k)));
      check("pass_vec", 32'(Pass_Vec),     32'(m_pass));
`ifdef GATE_TESTER_FAIL_LOG_EN
      check("fail_valid",   32'(Fail_Valid),   32'(m_fv));
      check("fail_pattern", 32'(Fail_Pattern), 32'(m_fp));
      check("fail_gates",   32'(Fail_Gates),   32'(m_fg));
`endif
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},    32'(Busy_Sig),     32'd0);
    check({tag, "_done"},    32'(Done_Sig),     32'd0);
    check({tag, "_gate_in"}, 32'(Test_Gate_In), 32'd0);
    check({tag, "_pass"},    32'(Pass_Vec),     32'd0);
`ifdef GATE_TESTER_FAIL_LOG_EN
    check({tag, "_fvalid"},  32'(Fail_Valid),   32'd0);
`endif
  endtask

  // One-cycle start from idle, then watch 40 cycles; optional re-pulse during cycle 8.
  task automatic run_watch(input bit pulse8, output int done_at, output int n_done,
                           output int busy_cnt, output logic [5:0] pass_at_done,
                           output logic [1:0] pat_seen [22]);
    done_at  = -1;
    n_done   = 0;
    busy_cnt = 0;
    pass_at_done = 6'h00;
    for (int i = 0; i < 22; i++) pat_seen[i] = 2'b00;
    Start_Sig = 1'b1;
    @(posedge CLK);
    #1 Start_Sig = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      if (c < 22) pat_seen[c] = Test_Gate_In;
      if (Busy_Sig) busy_cnt++;
      if (Done_Sig) begin
        n_done++;
        done_at = c;
        pass_at_done = Pass_Vec;
      end
      if (pulse8 && c == 8) Start_Sig = 1'b1;
      if (pulse8 && c == 9) Start_Sig = 1'b0;
    end
  endtask

  int         done_at;
  int         n_done;
  int         busy_cnt;
  logic [5:0] pass_d;
  logic [1:0] pat_seen [22];
  int         pat_idx [9];
  logic [1:0] pat_lit [9];

  initial begin
    RSTn      = 1'b1;
    Start_Sig = 1'b0;
    stuck0    = '0;
    for (int i = 0; i < 4; i++) inv_arr[i] = '0;
    #1 RSTn = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RSTn = 1'b1;
    check_reset_values("reset");
    chk_en = 1'b1;
    @(posedge CLK);
    #1;

    // Clean gate block.
    run_watch(1'b0, done_at, n_done, busy_cnt, pass_d, pat_seen);
    check("clean_done_cycle", 32'(done_at), 32'd21);
    check("clean_done_count", 32'(n_done), 32'd1);
    check("clean_busy_cycles", 32'(busy_cnt), 32'd21);
    check("clean_pass", 32'(pass_d), 32'h3f);
    pat_idx = '{1, 5, 6, 10, 11, 15, 16, 20, 21};
    pat_lit = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    for (int i = 0; i < 9; i++)
      check($sformatf("pattern_c%0d", pat_idx[i]), 32'(pat_seen[pat_idx[i]]), 32'(pat_lit[i]));

    // NAND stuck at 0.
    stuck0 = 6'b000010;
    run_watch(1'b0, done_at, n_done, busy_cnt, pass_d, pat_seen);
    check("nand_stuck_pass", 32'(pass_d), 32'h3d);
`ifdef GATE_TESTER_FAIL_LOG_EN
    check("nand_fail_valid", 32'(Fail_Valid), 32'd1);
    check("nand_fail_pattern", 32'(Fail_Pattern), 32'd0);
    check("nand_fail_gates", 32'(Fail_Gates), 32'h02);
`endif
    stuck0 = '0;

    // XOR inverted on every pattern.
    for (int i = 0; i < 4; i++) inv_arr[i] = 6'b010000;
    run_watch(1'b0, done_at, n_done, busy_cnt, pass_d, pat_seen);
    check("xor_inv_pass", 32'(pass_d), 32'h2f);
`ifdef GATE_TESTER_FAIL_LOG_EN
    check("xor_fail_pattern", 32'(Fail_Pattern), 32'd0);
`endif
    for (int i = 0; i < 4; i++) inv_arr[i] = '0;

    // Second start mid-run must be ignored.
    run_watch(1'b1, done_at, n_done, busy_cnt, pass_d, pat_seen);
    check("restart_done_cycle", 32'(done_at), 32'd21);
    check("restart_done_count", 32'(n_done), 32'd1);

    // Reset mid-run at cycle 10.
    Start_Sig = 1'b1;
    @(posedge CLK);
    #1 Start_Sig = 1'b0;
    repeat (9) @(posedge CLK);
    #1 RSTn = 1'b0;
    #1 check_reset_values("midreset");
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b1;
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK);
      if (Done_Sig) n_done++;
    end
    check("midreset_no_done", 32'(n_done), 32'd0);
    @(posedge CLK);
    #1;
    run_watch(1'b0, done_at, n_done, busy_cnt, pass_d, pat_seen);
    check("after_reset_done_cycle", 32'(done_at), 32'd21);
    check("after_reset_pass", 32'(pass_d), 32'h3f);

    // Randomized starts, faults and occasional resets; the per-cycle compare does the work.
    for (int c = 0; c < 1500; c++) begin
      @(posedge CLK);
      #1;
      if (!RSTn) RSTn = 1'b1;
      else if ($urandom_range(299) == 0) RSTn = 1'b0;
      if (k == 0 && $urandom_range(3) == 0) begin
        stuck0 = 6'($urandom) & 6'($urandom) & 6'($urandom);
        for (int i = 0; i < 4; i++) inv_arr[i] = 6'($urandom) & 6'($urandom) & 6'($urandom);
      end
      Start_Sig = ($urandom_range(2) == 0);
    end
    #1 RSTn = 1'b1;
    Start_Sig = 1'b0;
    repeat (30) @(posedge CLK);
    @(negedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
